// File: rtl/seq_fsm_param.sv
// Parameterised modulo-N state sequencer with load, hold, bidirectional stepping,
// illegal-state recovery, registered wrap/err pulses and a saturating wrap counter.
module seq_fsm_param #(
  parameter int NUM_STATES = 6,
  parameter int OUT_W      = 4,
  parameter int WCNT_W     = 8,
  localparam int SW        = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              dir,
  input  logic              hold,
  input  logic              load,
  input  logic [SW-1:0]     load_state,
  output logic [SW-1:0]     state,
  output logic [OUT_W-1:0]  out,
  output logic              wrap,
  output logic              err,
  output logic [WCNT_W-1:0] wrap_cnt
);

  // One extra bit so NUM_STATES itself is representable when it is a power of two.
  localparam logic [SW:0]   NUM_LIMIT  = (SW+1)'(NUM_STATES);
  localparam logic [SW-1:0] LAST_STATE = SW'(NUM_STATES - 1);

  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_RECOVER,
    ACT_LOAD,
    ACT_BAD_LOAD,
    ACT_HOLD,
    ACT_FWD,
    ACT_REV
  } action_e;

  action_e             action;
  logic                state_illegal;
  logic                load_illegal;

  logic [SW-1:0]       state_q, state_d;
  logic                wrap_q, wrap_d;
  logic                err_q, err_d;
  logic [WCNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;

  assign state_illegal = {1'b0, state_q} >= NUM_LIMIT;
  assign load_illegal  = {1'b0, load_state} >= NUM_LIMIT;

  // Priority: recovery, load, hold, step.
  always_comb begin
    action = ACT_IDLE;
    if (state_illegal) begin
      action = ACT_RECOVER;
    end else if (load) begin
      action = load_illegal ? ACT_BAD_LOAD : ACT_LOAD;
    end else if (hold) begin
      action = ACT_HOLD;
    end else if (en) begin
      action = dir ? ACT_REV : ACT_FWD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= '0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    case (action)
      ACT_RECOVER: begin
        state_d = '0;
        err_d   = 1'b1;
      end
      ACT_LOAD: begin
        state_d = load_state;
      end
      ACT_BAD_LOAD: begin
        err_d = 1'b1;
      end
      ACT_HOLD, ACT_IDLE: begin
        state_d = state_q;
      end
      ACT_FWD: begin
        if (state_q == LAST_STATE) begin
          state_d = '0;
          wrap_d  = 1'b1;
        end else begin
          state_d = state_q + SW'(1);
        end
      end
      ACT_REV: begin
        if (state_q == '0) begin
          state_d = LAST_STATE;
          wrap_d  = 1'b1;
        end else begin
          state_d = state_q - SW'(1);
        end
      end
      default: begin
        state_d = '0;
      end
    endcase
  end

  // The counter sticks at all-ones while wrap keeps pulsing.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_d && (wrap_cnt_q != '1)) begin
      wrap_cnt_d = wrap_cnt_q + WCNT_W'(1);
    end
  end

  always_comb begin
    state           = state_q;
    out             = '0;
    out[SW-1:0]     = state_q;
    wrap            = wrap_q;
    err             = err_q;
    wrap_cnt        = wrap_cnt_q;
  end

endmodule

// File: tb/tb_seq_fsm_param.sv
// Directed and random checks of seq_fsm_param (NUM_STATES=6) against an
// integer reference model of the sequencing rules.
module tb_seq_fsm_param;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       hold;
  logic       load;
  logic [2:0] load_state;
  logic [2:0] state;
  logic [3:0] out;
  logic       wrap;
  logic       err;
  logic [7:0] wrap_cnt;

  int checks = 0;
  int errors = 0;

  int ms   = 0;
  int mcnt = 0;
  bit mwrap = 1'b0;
  bit merr  = 1'b0;

  seq_fsm_param #(.NUM_STATES(6), .OUT_W(4), .WCNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .dir        (dir),
    .hold       (hold),
    .load       (load),
    .load_state (load_state),
    .state      (state),
    .out        (out),
    .wrap       (wrap),
    .err        (err),
    .wrap_cnt   (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    ms    = 0;
    mcnt  = 0;
    mwrap = 1'b0;
    merr  = 1'b0;
  endtask

  task automatic modelStep(input bit e, input bit d, input bit h, input bit l, input int ls);
    mwrap = 1'b0;
    merr  = 1'b0;
    if (ms >= 6) begin
      ms   = 0;
      merr = 1'b1;
    end else if (l) begin
      if (ls < 6) ms = ls;
      else merr = 1'b1;
    end else if (!h && e) begin
      if (!d) begin
        mwrap = (ms == 5);
        ms    = (ms + 1) % 6;
      end else begin
        mwrap = (ms == 0);
        ms    = (ms + 5) % 6;
      end
    end
    if (mwrap && mcnt < 255) mcnt = mcnt + 1;
  endtask

  task automatic checkOutput(input string tag);
    logic [2:0] es;
    logic [3:0] eo;
    logic [7:0] ec;
    es = 3'(ms);
    eo = 4'(ms);
    ec = 8'(mcnt);
    checks++;
    assert (state === es) else begin
      errors++;
      $error("[TB] FAIL %s state got %0d exp %0d", tag, state, es);
    end
    checks++;
    assert (out === eo) else begin
      errors++;
      $error("[TB] FAIL %s out got %0h exp %0h", tag, out, eo);
    end
    checks++;
    assert (wrap === mwrap) else begin
      errors++;
      $error("[TB] FAIL %s wrap got %0b exp %0b", tag, wrap, mwrap);
    end
    checks++;
    assert (err === merr) else begin
      errors++;
      $error("[TB] FAIL %s err got %0b exp %0b", tag, err, merr);
    end
    checks++;
    assert (wrap_cnt === ec) else begin
      errors++;
      $error("[TB] FAIL %s wrap_cnt got %0d exp %0d", tag, wrap_cnt, ec);
    end
  endtask

  task automatic applyStimulus(input string tag, input bit e, input bit d, input bit h,
                               input bit l, input int ls);
    en         = e;
    dir        = d;
    hold       = h;
    load       = l;
    load_state = 3'(ls);
    @(posedge clk);
    modelStep(e, d, h, l, ls);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst_n = 1'b1;
    en = 1'b0; dir = 1'b0; hold = 1'b0; load = 1'b0; load_state = 3'd0;

    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("reset");

    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 7; i++) applyStimulus("fwd7", 1, 0, 0, 0, 0);

    @(negedge clk) rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("reset2");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 2; i++) applyStimulus("rev2", 1, 1, 0, 0, 0);

    applyStimulus("load3", 0, 0, 0, 1, 3);
    applyStimulus("badload6", 1, 0, 0, 1, 6);
    applyStimulus("load2", 0, 0, 0, 1, 2);
    applyStimulus("idle", 0, 0, 0, 0, 0);

    applyStimulus("load4", 0, 0, 0, 1, 4);
    for (int i = 0; i < 3; i++) applyStimulus("hold", 1, i[0], 1, 0, 0);
    applyStimulus("holdload1", 1, 0, 1, 1, 1);

    @(negedge clk);
    force dut.state_q = 3'd7;
    #1;
    release dut.state_q;
    ms = 7;
    en = 1'b1; dir = 1'b0; hold = 1'b0; load = 1'b1; load_state = 3'd2;
    #1;
    checks++;
    assert (state === 3'd7) else begin
      errors++;
      $error("[TB] FAIL backdoor state got %0d exp 7", state);
    end
    applyStimulus("recover", 1, 0, 0, 1, 2);
    applyStimulus("after_recover", 0, 0, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      applyStimulus("random", bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 7)));
    end

    @(negedge clk) rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("reset3");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 300 * 6; i++) applyStimulus("saturate", 1, 0, 0, 0, 0);

    en = 1'b1; dir = 1'b0; hold = 1'b0; load = 1'b0;
    @(posedge clk);
    modelStep(1, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("mid_reset");
    @(posedge clk);
    #1;
    checkOutput("in_reset");
    @(negedge clk) rst_n = 1'b1;
    #1;
    checkOutput("post_release");
    applyStimulus("first_step", 1, 1, 0, 0, 0);
    applyStimulus("second_step", 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
